pix_scan: RTL and testbench

PIX_SCAN -- requirements
Module: pix_scan

---
 rtl/img_pkg.sv | 22 ++
 rtl/pix_scan_coord_counter.sv | 70 +++++++
 rtl/pix_scan.sv | 191 +++++++++++++++++++
 tb/tb_pix_scan.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the pixel scanner: default image geometry, coordinate
// and pixel widths, and the scan FSM state type.
// -----------------------------------------------------------------------------
package img_pkg;

    localparam int IMG_W_DEF = 320;   // pixels per row
    localparam int IMG_H_DEF = 240;   // rows per frame
    localparam int I_W       = 9;     // column coordinate width
    localparam int J_W       = 8;     // row coordinate width
    localparam int PIX_W     = 12;    // RGB444 pixel width

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EMIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } scan_state_e;

endpackage : img_pkg

// File: rtl/pix_scan_coord_counter.sv
// -----------------------------------------------------------------------------
// coord_counter
// Raster-order (i,j) coordinate counter. Column i advances on each increment
// and wraps to 0 at IMG_W-1, carrying into row j. The counter saturates at the
// last pixel (IMG_W-1, IMG_H-1) instead of wrapping the frame.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force counter to (0,0) (priority over inc)
//   inc        : advance one pixel in raster order
//   i_cnt      : current column
//   j_cnt      : current row
//   last       : counter sits on the final pixel of the frame
// -----------------------------------------------------------------------------
module coord_counter
    import img_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           inc,
    output logic [I_W-1:0] i_cnt,
    output logic [J_W-1:0] j_cnt,
    output logic           last
);

    localparam logic [I_W-1:0] I_LAST = I_W'(IMG_W - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(IMG_H - 1);

    logic [I_W-1:0] i_q, i_d;
    logic [J_W-1:0] j_q, j_d;

    assign last  = (i_q == I_LAST) && (j_q == J_LAST);
    assign i_cnt = i_q;
    assign j_cnt = j_q;

    // NOTE: every signal driven here gets its hold value first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
        end else if (inc && !last) begin
            if (i_q == I_LAST) begin
                i_d = '0;
                j_d = j_q + J_W'(1);
            end else begin
                i_d = i_q + I_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

endmodule : coord_counter

// File: rtl/pix_scan.sv
// -----------------------------------------------------------------------------
// pix_scan
// Streams one frame of RGB444 pixels from an upstream valid/ready source to a
// masking stage. Each accepted pixel is presented with its raster coordinates
// and the frame's latched mask offsets, strobed by a single-cycle registered
// tx pulse, then held for HOLD_CYC cycles before the next pixel is accepted.
//
// Configuration macro: SCAN_AUTO_RESTART_EN
//   defined   : DONE restarts the next frame directly (counter cleared,
//               offsets re-latched); only abort or reset returns to IDLE.
//   undefined : DONE always returns to IDLE.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : one-cycle frame request, honoured only in IDLE
//   abort             : return to IDLE on the next edge from any state
//   i_offset_in       : mask column offset, latched when a frame starts
//   j_offset_in       : mask row offset, latched when a frame starts
//   in_valid/in_pixel : upstream pixel stream, raster order
//   in_ready          : pixel accepted this cycle when in_valid is also high
//   pixel, i_p, j_p   : pixel under presentation and its column/row
//   i_offset/j_offset : offsets latched for the current frame
//   tx                : one-cycle strobe, masking stage samples on its rise
//   busy              : high in every state except IDLE
//   frame_done        : one-cycle pulse after the last pixel's hold period
// -----------------------------------------------------------------------------
module pix_scan
    import img_pkg::*;
#(
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF,
    parameter int HOLD_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [I_W-1:0]   i_offset_in,
    input  logic [J_W-1:0]   j_offset_in,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             in_ready,
    output logic [PIX_W-1:0] pixel,
    output logic [I_W-1:0]   i_p,
    output logic [J_W-1:0]   j_p,
    output logic [I_W-1:0]   i_offset,
    output logic [J_W-1:0]   j_offset,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    // Hold counter counts down from HOLD_CYC-1 to 0, one step per HOLD cycle.
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);

    scan_state_e      state_q, state_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic [I_W-1:0]   i_p_q, i_p_d;
    logic [J_W-1:0]   j_p_q, j_p_d;
    logic [I_W-1:0]   i_off_q, i_off_d;
    logic [J_W-1:0]   j_off_q, j_off_d;
    logic [3:0]       hold_q, hold_d;
    logic             emit_last_q, emit_last_d;  // presented pixel ends the frame
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    logic             cnt_clr;
    logic             cnt_inc;
    logic [I_W-1:0]   i_cnt;
    logic [J_W-1:0]   j_cnt;
    logic             cnt_last;

    coord_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_coord (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .i_cnt (i_cnt),
        .j_cnt (j_cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        pixel_d     = pixel_q;
        i_p_d       = i_p_q;
        j_p_d       = j_p_q;
        i_off_d     = i_off_q;
        j_off_d     = j_off_q;
        hold_d      = hold_q;
        emit_last_d = emit_last_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;

        if (abort) begin
            // Abort outranks everything, including a simultaneous start or an
            // in-flight handshake.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_LOAD;
                        i_off_d = i_offset_in;
                        j_off_d = j_offset_in;
                        cnt_clr = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        pixel_d     = in_pixel;
                        i_p_d       = i_cnt;
                        j_p_d       = j_cnt;
                        emit_last_d = cnt_last;
                        cnt_inc     = 1'b1;
                        state_d     = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_q == 4'd0) begin
                        state_d = emit_last_q ? ST_DONE : ST_LOAD;
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
                ST_DONE: begin
`ifdef SCAN_AUTO_RESTART_EN
                    state_d = ST_LOAD;
                    i_off_d = i_offset_in;
                    j_off_d = j_offset_in;
                    cnt_clr = 1'b1;
`else
                    state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Strobes are registered copies of the state being entered, so they
        // are glitch-free and aligned exactly with EMIT / DONE.
        tx_d   = (state_d == ST_EMIT);
        done_d = (state_d == ST_DONE);
    end

    // NOTE: datapath registers are reset along with control because every
    // output, including pixel, coordinates and offsets, must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pixel_q     <= '0;
            i_p_q       <= '0;
            j_p_q       <= '0;
            i_off_q     <= '0;
            j_off_q     <= '0;
            hold_q      <= '0;
            emit_last_q <= 1'b0;
            tx_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pixel_q     <= pixel_d;
            i_p_q       <= i_p_d;
            j_p_q       <= j_p_d;
            i_off_q     <= i_off_d;
            j_off_q     <= j_off_d;
            hold_q      <= hold_d;
            emit_last_q <= emit_last_d;
            tx_q        <= tx_d;
            done_q      <= done_d;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_IDLE);
    assign pixel      = pixel_q;
    assign i_p        = i_p_q;
    assign j_p        = j_p_q;
    assign i_offset   = i_off_q;
    assign j_offset   = j_off_q;
    assign tx         = tx_q;
    assign frame_done = done_q;

endmodule : pix_scan

// File: tb/tb_pix_scan.sv
// -----------------------------------------------------------------------------
// tb_pix_scan
// Self-checking bench for pix_scan on a 4x3 image with HOLD_CYC=1. A timing
// model derived from the block's handshake/latency rules predicts every
// output on every cycle; directed tests add literal expectations for frame
// order, stalls, offset latching, abort and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pix_scan;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HC = 1;
`ifdef SCAN_AUTO_RESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [8:0]  ioff_in = '0;
    logic [7:0]  joff_in = '0;
    logic        in_valid = 1'b0;
    logic [11:0] in_pixel = '0;
    logic        in_ready;
    logic [11:0] pixel;
    logic [8:0]  i_p;
    logic [7:0]  j_p;
    logic [8:0]  i_offset;
    logic [7:0]  j_offset;
    logic        tx;
    logic        busy;
    logic        frame_done;

    pix_scan #(.IMG_W(W), .IMG_H(H), .HOLD_CYC(HC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .i_offset_in (ioff_in),
        .j_offset_in (joff_in),
        .in_valid    (in_valid),
        .in_pixel    (in_pixel),
        .in_ready    (in_ready),
        .pixel       (pixel),
        .i_p         (i_p),
        .j_p         (j_p),
        .i_offset    (i_offset),
        .j_offset    (j_offset),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Fresh pixel data every cycle so captured values are distinguishable.
    always @(posedge clk) begin
        #1;
        in_pixel = 12'($urandom);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is a sequence of accepted pixels; pixel n sits at (n%W, n/W).
    // Accept at the edge closing cycle k => tx in cycle k+1, ready again in
    // cycle k+2+HC, or (last pixel) frame_done in cycle k+2+HC.
    bit          m_busy     = 1'b0;
    int          m_ready_at = -1;
    int          m_tx_at    = -1;
    int          m_done_at  = -1;
    int          m_n        = 0;
    logic [11:0] e_pix  = '0;
    int          e_i    = 0;
    int          e_j    = 0;
    int          e_ioff = 0;
    int          e_joff = 0;
    bit          e_tx, e_done, e_ready;

    // Observation log used by the directed tests.
    int tx_cyc[$];
    int tx_i[$];
    int tx_j[$];
    int done_cnt = 0;
    int done_cyc = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs",
                  {tx, busy, frame_done, in_ready, pixel, i_p, j_p, i_offset, j_offset}, 64'd0);
            m_busy = 1'b0; m_ready_at = -1; m_tx_at = -1; m_done_at = -1; m_n = 0;
            e_pix = '0; e_i = 0; e_j = 0; e_ioff = 0; e_joff = 0;
        end else begin
            e_tx    = (cyc == m_tx_at);
            e_done  = m_busy && (cyc == m_done_at);
            e_ready = m_busy && (m_ready_at >= 0) && (cyc >= m_ready_at);
            check("tx",         tx,         e_tx);
            check("frame_done", frame_done, e_done);
            check("in_ready",   in_ready,   e_ready);
            check("busy",       busy,       m_busy);
            check("pixel",      pixel,      e_pix);
            check("i_p",        i_p,        e_i);
            check("j_p",        j_p,        e_j);
            check("i_offset",   i_offset,   e_ioff);
            check("j_offset",   j_offset,   e_joff);

            if (tx) begin
                tx_cyc.push_back(cyc);
                tx_i.push_back(int'(i_p));
                tx_j.push_back(int'(j_p));
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            // Reaction to the inputs sampled at the coming edge.
            if (abort) begin
                m_busy = 1'b0; m_ready_at = -1; m_tx_at = -1; m_done_at = -1;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1; m_ready_at = cyc + 1; m_n = 0;
                    e_ioff = int'(ioff_in); e_joff = int'(joff_in);
                end
            end else if (e_ready && in_valid) begin
                e_pix = in_pixel; e_i = m_n % W; e_j = m_n / W;
                m_tx_at = cyc + 1;
                if (m_n == W * H - 1) begin
                    m_ready_at = -1;
                    m_done_at  = cyc + 2 + HC;
                end else begin
                    m_ready_at = cyc + 2 + HC;
                end
                m_n++;
            end else if (e_done) begin
                if (AUTO) begin
                    m_n = 0; m_ready_at = cyc + 1;
                    e_ioff = int'(ioff_in); e_joff = int'(joff_in);
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_log();
        tx_cyc.delete(); tx_i.delete(); tx_j.delete();
        done_cnt = 0; done_cyc = -1;
    endtask

    task automatic do_start(input logic [8:0] io, input logic [7:0] jo);
        @(posedge clk); #1;
        ioff_in = io; joff_in = jo; start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(posedge clk); #1;
        abort = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    // Returns at the negedge of the tx cycle presenting (wi,wj).
    task automatic wait_tx_at(input int wi, input int wj, input int lim, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < lim && !ok; k++) begin
            @(negedge clk);
            if (tx && int'(i_p) == wi && int'(j_p) == wj) ok = 1'b1;
        end
        if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_any_tx(input int lim, input string name, output int oi, output int oj);
        bit ok = 1'b0;
        oi = -1; oj = -1;
        for (int k = 0; k < lim && !ok; k++) begin
            @(negedge clk);
            if (tx) begin ok = 1'b1; oi = int'(i_p); oj = int'(j_p); end
        end
        if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_done(input int lim, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < lim && !ok; k++) begin
            @(negedge clk);
            if (frame_done) ok = 1'b1;
        end
        if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int ci, cj;
        bit ok;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("init_busy", busy, 1'b0);
        check("init_ready", in_ready, 1'b0);

        // Full frame, in_valid held high, offsets change mid-frame.
        clear_log();
        do_start(9'd10, 8'd20);
        repeat (4) @(posedge clk);
        #1 ioff_in = 9'd99; joff_in = 8'd99;
        wait_done(200, "A_done");
        check("A_ioff_at_done", i_offset, 9'd10);
        check("A_joff_at_done", j_offset, 8'd20);
        @(negedge clk);
        check("A_tx_count", tx_cyc.size(), 12);
        check("A_done_count", done_cnt, 1);
        check("A_busy_after", busy, AUTO);
        if (tx_cyc.size() == 12) begin
            check("A_first_ij", {tx_i[0], tx_j[0]}, {32'd0, 32'd0});
            check("A_5th_ij",   {tx_i[4], tx_j[4]}, {32'd0, 32'd1});
            check("A_last_ij",  {tx_i[11], tx_j[11]}, {32'd3, 32'd2});
            check("A_done_lat", done_cyc - tx_cyc[11], 2);
            for (int k = 1; k < 12; k++) check("A_spacing", tx_cyc[k] - tx_cyc[k-1], 3);
        end
        do_abort();

        // Upstream stall after pixel (1,0).
        clear_log();
        do_start(9'd3, 8'd4);
        wait_tx_at(1, 0, 50, "B_tx10");
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b1;
        wait_any_tx(20, "B_next", ci, cj);
        check("B_next_i", ci, 2);
        check("B_next_j", cj, 0);
        do_abort();

        // Abort together with start while waiting for pixel (2,1).
        clear_log();
        do_start(9'd1, 8'd2);
        wait_tx_at(1, 1, 80, "C_tx11");
        @(posedge clk); #1 in_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) check("C_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("C_idle_busy", busy, 1'b0);
        repeat (4) @(posedge clk);
        #1 check("C_still_idle", busy, 1'b0);
        check("C_no_done", done_cnt, 0);
        do_start(9'd7, 8'd8);
        wait_any_tx(20, "C_restart", ci, cj);
        check("C_restart_ij", {ci, cj}, {32'd0, 32'd0});
        do_abort();

        // Asynchronous reset during EMIT.
        clear_log();
        do_start(9'd5, 8'd6);
        wait_any_tx(20, "D_tx", ci, cj);
        #1 rst_n = 1'b0;
        #1;
        check("D_tx_async", tx, 1'b0);
        check("D_busy_async", busy, 1'b0);
        check("D_ioff_async", i_offset, 9'd0);
        check("D_pixel_async", pixel, 12'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b1;
        clear_log();
        repeat (8) @(posedge clk);
        #1 check("D_no_tx_after_reset", tx_cyc.size(), 0);
        check("D_idle_after_reset", busy, 1'b0);
        in_valid = 1'b0;

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pix_scan
